// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI arbiter.
//   arb_state_t : arbiter FSM states
//   req_id_t    : identifies the granted requester
//   cnt_width   : width of the shared timeout/gap down-counter
package spi_arb_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, XFER, DONE, GAP} arb_state_t;
  typedef enum logic {REQ_A2D, REQ_INERT} req_id_t;

  // The timer is shared by the timeout and gap phases, so it has to be
  // wide enough for whichever terminal count is larger.
  function automatic int cnt_width(input int a, input int b);
    int w;
    w = (a > b) ? a : b;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bus between the arbiter and the single SPI master.
//   spi_snd   : 1-cycle start strobe to the master
//   spi_cmd   : command word, stable from LAUNCH through XFER
//   spi_done  : master completion pulse
//   spi_resp  : master response, valid with spi_done
//   sel_inert : 1 = inertial slave selected (steers SS and MISO muxes)
// modport master : arbiter side; modport slave : SPI master side.
interface spi_arbiter_if;
  logic        spi_snd;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_resp;
  logic        sel_inert;

  modport master (output spi_snd, spi_cmd, sel_inert, input spi_done, spi_resp);
  modport slave  (input spi_snd, spi_cmd, sel_inert, output spi_done, spi_resp);
endinterface

// File: rtl/spi_arb_timer.sv
// Saturating down-counter used for both the XFER timeout and the GAP length.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over count)
//   load_val   : terminal-count start value
//   count      : decrement by one, holding at zero
//   expired    : counter is at zero
module spi_arb_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between the A2D sequencer and the inertial interface:
// arbitrates, launches the granted command, waits for completion (or timeout),
// returns the response and then holds off for a guard gap. All outputs are
// registered.
//   clk, rst_n               : clock, async active-low reset
//   a2d_req/cmd/gnt/done     : A2D requester handshake
//   inert_req/cmd/gnt/done   : inertial requester handshake
//   rsp, tmo_err             : response word and timeout flag (with done)
//   spi                      : master-side bus (spi_arbiter_if.master)
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int INERT_PRIO = 1,
  parameter int GAP_CYC    = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a2d_req,
  input  logic [15:0]   a2d_cmd,
  output logic          a2d_gnt,
  output logic          a2d_done,
  input  logic          inert_req,
  input  logic [15:0]   inert_cmd,
  output logic          inert_gnt,
  output logic          inert_done,
  output logic [15:0]   rsp,
  output logic          tmo_err,
  spi_arbiter_if.master spi
);

  localparam int CW = cnt_width($clog2(TIMEOUT + 1), $clog2(GAP_CYC + 1));
  localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT);
  // Loaded on entry to GAP; GAP exits in the cycle the count reaches zero.
  localparam logic [CW-1:0] GAP_LD = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  arb_state_t    state, state_nxt;
  req_id_t       pick;
  logic          snd_q, snd_nxt;
  logic [15:0]   cmd_q, cmd_nxt;
  logic          sel_q, sel_nxt;
  logic          a2d_gnt_nxt, inert_gnt_nxt;
  logic          a2d_done_nxt, inert_done_nxt;
  logic [15:0]   rsp_nxt;
  logic          tmo_nxt;
  logic          last_inert, last_nxt;
  logic          tmr_load, tmr_count, tmr_expired;
  logic [CW-1:0] tmr_val;

  spi_arb_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pick           = REQ_A2D;
    snd_nxt        = 1'b0;
    cmd_nxt        = cmd_q;
    sel_nxt        = sel_q;
    a2d_gnt_nxt    = a2d_gnt;
    inert_gnt_nxt  = inert_gnt;
    a2d_done_nxt   = 1'b0;
    inert_done_nxt = 1'b0;
    rsp_nxt        = rsp;
    tmo_nxt        = 1'b0;
    last_nxt       = last_inert;
    tmr_load       = 1'b0;
    tmr_val        = '0;
    tmr_count      = 1'b0;

    // Inertial wins a tie under priority mode, or in round-robin when A2D
    // was served last.
    if (inert_req && (!a2d_req || (INERT_PRIO != 0) || !last_inert))
      pick = REQ_INERT;

    unique case (state)
      IDLE: begin
        if (a2d_req || inert_req) begin
          state_nxt     = LAUNCH;
          snd_nxt       = 1'b1;
          sel_nxt       = (pick == REQ_INERT);
          cmd_nxt       = (pick == REQ_INERT) ? inert_cmd : a2d_cmd;
          a2d_gnt_nxt   = (pick == REQ_A2D);
          inert_gnt_nxt = (pick == REQ_INERT);
        end
      end
      LAUNCH: begin
        state_nxt = XFER;
        tmr_load  = 1'b1;
        tmr_val   = TMO_LD;
      end
      XFER: begin
        if (spi.spi_done || tmr_expired) begin
          state_nxt      = DONE;
          a2d_done_nxt   = !sel_q;
          inert_done_nxt = sel_q;
          a2d_gnt_nxt    = 1'b0;
          inert_gnt_nxt  = 1'b0;
          last_nxt       = sel_q;
          rsp_nxt        = spi.spi_done ? spi.spi_resp : 16'h0000;
          tmo_nxt        = !spi.spi_done;
        end else begin
          tmr_count = 1'b1;
        end
      end
      DONE: begin
        if (GAP_CYC > 0) begin
          state_nxt = GAP;
          tmr_load  = 1'b1;
          tmr_val   = GAP_LD;
        end else begin
          state_nxt = IDLE;
          sel_nxt   = 1'b0;
        end
      end
      GAP: begin
        if (tmr_expired) begin
          state_nxt = IDLE;
          sel_nxt   = 1'b0;
        end else begin
          tmr_count = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snd_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      sel_q      <= 1'b0;
      a2d_gnt    <= 1'b0;
      inert_gnt  <= 1'b0;
      a2d_done   <= 1'b0;
      inert_done <= 1'b0;
      rsp        <= 16'h0000;
      tmo_err    <= 1'b0;
      last_inert <= 1'b1;
    end else begin
      snd_q      <= snd_nxt;
      cmd_q      <= cmd_nxt;
      sel_q      <= sel_nxt;
      a2d_gnt    <= a2d_gnt_nxt;
      inert_gnt  <= inert_gnt_nxt;
      a2d_done   <= a2d_done_nxt;
      inert_done <= inert_done_nxt;
      rsp        <= rsp_nxt;
      tmo_err    <= tmo_nxt;
      last_inert <= last_nxt;
    end
  end

  assign spi.spi_snd   = snd_q;
  assign spi.spi_cmd   = cmd_q;
  assign spi.sel_inert = sel_q;

endmodule
